// File: rtl/sdram_fb_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_fb_arbiter
//
// Shares the single SDRAM Avalon-MM master of the frame-buffer path between
// the display reader (real-time, priority) and the camera writer. The writer
// gets a bandwidth guarantee: after MAX_RD_STREAK consecutive read grants
// with a write pending, the next burst goes to the writer. Every burst is
// BURST_LEN beats, and at least one IDLE cycle separates two bursts.
//
// Ports
//   clk_clk, reset_reset_n      clock, asynchronous active-low reset
//   rd_req / rd_addr            display read request + burst start address
//   rd_gnt                      read command accepted this cycle
//   rd_data / rd_valid          returned read beat (1 cycle after the bus)
//   rd_done                     coincides with the final rd_valid of a burst
//   wr_req / wr_addr            camera write request + burst start address
//   wr_data / wr_data_ack       first-word-fall-through write source + pop
//   wr_done                     one-cycle pulse after the last write beat
//   av_*                        Avalon-MM master towards the SDRAM controller
//   busy                        a burst is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module sdram_fb_arbiter #(
    parameter int ADDR_W        = 25,
    parameter int DATA_W        = 32,
    parameter int BURST_LEN     = 8,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_ack,
    output logic              wr_done,
    output logic [ADDR_W-1:0] av_address,
    output logic [7:0]        av_burstcount,
    output logic              av_read,
    output logic              av_write,
    output logic [DATA_W-1:0] av_writedata,
    input  logic              av_waitrequest,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_readdatavalid,
    output logic              busy
);

    localparam int                  STREAK_W   = (MAX_RD_STREAK < 1) ? 1 : $clog2(MAX_RD_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);
    localparam logic [7:0]          LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [7:0]          BURST_CNT  = 8'(BURST_LEN);

    // av_burstcount is only 8 bits wide, so longer bursts cannot be expressed.
    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("sdram_fb_arbiter: BURST_LEN must be in 1..255");
    end
    if (MAX_RD_STREAK < 1) begin : g_bad_streak
        $error("sdram_fb_arbiter: MAX_RD_STREAK must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_CMD   = 2'd1,
        RD_DATA  = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [7:0]          beat_cnt;
    logic [STREAK_W-1:0] streak;

    logic force_wr;
    logic take_rd;
    logic rd_beat;
    logic last_rd_beat;
    logic wr_ack;
    logic last_wr_beat;

    // Saturating increment of the read-streak counter.
    function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] cur);
        if (cur >= STREAK_MAX) begin
            return STREAK_MAX;
        end
        return cur + STREAK_W'(1);
    endfunction

    assign force_wr     = wr_req && (streak >= STREAK_MAX);
    assign take_rd      = rd_req && !force_wr;
    // Beats arriving in any other state (e.g. left over from a burst that a
    // reset abandoned) are dropped here.
    assign rd_beat      = av_readdatavalid && ((state == RD_CMD) || (state == RD_DATA));
    assign last_rd_beat = rd_beat && (beat_cnt == LAST_BEAT);
    assign wr_ack       = (state == WR_BURST) && !av_waitrequest;
    assign last_wr_beat = wr_ack && (beat_cnt == LAST_BEAT);

    // ---- state register ----
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_rd) begin
                    state_nxt = RD_CMD;
                end else if (wr_req) begin
                    state_nxt = WR_BURST;
                end
            end
            RD_CMD: begin
                if (last_rd_beat) begin
                    state_nxt = IDLE;
                end else if (!av_waitrequest) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (last_rd_beat) begin
                    state_nxt = IDLE;
                end
            end
            WR_BURST: begin
                if (last_wr_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- bus outputs (decoded from state so a reset drops them at once) ----
    always_comb begin
        av_read       = 1'b0;
        av_write      = 1'b0;
        av_address    = '0;
        av_burstcount = 8'd0;
        av_writedata  = '0;
        rd_gnt        = 1'b0;
        wr_data_ack   = 1'b0;
        busy          = (state != IDLE);
        case (state)
            RD_CMD: begin
                av_read       = 1'b1;
                av_address    = cmd_addr;
                av_burstcount = BURST_CNT;
                rd_gnt        = !av_waitrequest;
            end
            WR_BURST: begin
                av_write      = 1'b1;
                av_address    = cmd_addr;
                av_burstcount = BURST_CNT;
                av_writedata  = wr_data;
                wr_data_ack   = wr_ack;
            end
            default: ;
        endcase
    end

    // ---- burst bookkeeping and read-return register ----
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_addr <= '0;
            beat_cnt <= 8'd0;
            streak   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            rd_valid <= rd_beat;
            rd_done  <= last_rd_beat;
            wr_done  <= last_wr_beat;
            if (rd_beat) begin
                rd_data <= av_readdata;
            end

            case (state)
                IDLE: begin
                    beat_cnt <= 8'd0;
                    if (take_rd) begin
                        cmd_addr <= rd_addr;
                        // The streak only grows while a writer is actually waiting.
                        streak   <= wr_req ? streak_sat_inc(streak) : '0;
                    end else if (wr_req) begin
                        cmd_addr <= wr_addr;
                    end
                end
                RD_CMD, RD_DATA: begin
                    if (rd_beat) begin
                        beat_cnt <= last_rd_beat ? 8'd0 : beat_cnt + 8'd1;
                    end
                end
                WR_BURST: begin
                    if (wr_ack) begin
                        beat_cnt <= last_wr_beat ? 8'd0 : beat_cnt + 8'd1;
                    end
                    if (last_wr_beat) begin
                        streak <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
